// File: rtl/cnn_window_serializer_pkg.sv
// Shared definitions for the CNN window serializer: FSM state encoding and counter sizing.
package cnn_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  // Beat counter width: max(1, ceil(log2(n))), so N=1 and N=2 still get one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_window_serializer_if.sv
// Window-in / element-out handshake bundle; master drives windows and consumes beats, slave is the serializer.
interface cnn_window_serializer_if #(
  parameter int IN_WIDTH = 12,
  parameter int N        = 5
);
  logic [IN_WIDTH*N-1:0] x_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   x_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output x_in, in_valid, out_ready,
    input  in_ready, x_out, out_valid, out_last
  );

  modport slave (
    input  x_in, in_valid, out_ready,
    output in_ready, x_out, out_valid, out_last
  );
endinterface

// File: rtl/cnn_window_serializer.sv
// Serializes an N-element parallel window into N beats; first beat the cycle after accept, stalls hold all state.
// CNN_SERIALIZER_REVERSE_EN emits the highest element first; default emits element 0 first.
module cnn_window_serializer
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH = 12,
  parameter int N        = 5
) (
  input logic                 clk,
  input logic                 rst,
  cnn_window_serializer_if.slave bus
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                state;
  logic [IN_WIDTH*N-1:0] hold;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;
  logic [IN_WIDTH-1:0]   x_out_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  at_last;
  logic                  in_ready_c;
  logic                  accept;
  logic                  consume;

  // Beat k of a window maps to a held element index according to emission order.
  function automatic logic [IN_WIDTH-1:0] pick(input logic [IN_WIDTH*N-1:0] win,
                                               input logic [CW-1:0]         k);
    int idx;
`ifdef CNN_SERIALIZER_REVERSE_EN
    idx = N - 1 - int'(k);
`else
    idx = int'(k);
`endif
    return win[idx*IN_WIDTH +: IN_WIDTH];
  endfunction

  assign cnt_inc = cnt + CW'(1);
  assign at_last = (cnt == LAST);

  // Ready on the last beat's consume lets the next window follow with no bubble.
  assign in_ready_c = (state == IDLE) || (at_last && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign consume    = (state == SHIFT) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      cnt         <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      state       <= SHIFT;
      hold        <= bus.x_in;
      cnt         <= '0;
      x_out_q     <= pick(bus.x_in, CW'(0));
      out_valid_q <= 1'b1;
      out_last_q  <= (LAST == CW'(0));
    end else if (consume) begin
      if (at_last) begin
        state       <= IDLE;
        cnt         <= '0;
        x_out_q     <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        cnt        <= cnt_inc;
        x_out_q    <= pick(hold, cnt_inc);
        out_last_q <= (cnt_inc == LAST);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.x_out     = x_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/cnn_window_serializer.md
CNN_WINDOW_SERIALIZER -- requirements
Module: cnn_window_serializer

Interface
REQ-001 Parameter IN_WIDTH, default 12, SHALL set the bit width of one element.
REQ-002 Parameter N, default 5, SHALL set the number of elements per window (kernel length); legal range 1..64.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 x_in  input  IN_WIDTH*N  SHALL carry a parallel window; element j occupies x_in[j*IN_WIDTH +: IN_WIDTH].
REQ-006 in_valid  input  1  SHALL mark x_in valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a window this cycle.
REQ-008 x_out  output  IN_WIDTH  SHALL carry the current serial element.
REQ-009 out_valid  output  1  SHALL mark x_out valid.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer accepts x_out.
REQ-011 out_last  output  1  SHALL mark the final element of a window.

Function
REQ-012 States: IDLE, SHIFT; a window is accepted on in_valid && in_ready, and a beat is consumed on out_valid && out_ready.
REQ-013 IDLE: in_ready=1, out_valid=0, out_last=0; on accept, x_in SHALL be captured in a holding register, beat counter cleared to 0, next state SHIFT.
REQ-014 SHIFT: out_valid=1; x_out SHALL equal held element cnt; out_last=1 iff cnt==N-1.
REQ-015 SHIFT, beat consumed with cnt<N-1: cnt SHALL increment by 1.
REQ-016 SHIFT, beat consumed with cnt==N-1 and no accept: next state IDLE.
REQ-017 in_ready SHALL be 1 in SHIFT only when cnt==N-1 and out_ready==1 (combinational path allowed); simultaneous last-beat consume and accept SHALL reload the holding register, clear cnt, and remain in SHIFT (zero-bubble back-to-back windows, N cycles per window).
REQ-018 Stall (out_valid && !out_ready): x_out, out_last, cnt and holding register SHALL remain unchanged.
REQ-019 Latency: first element SHALL appear on x_out the cycle after accept.
REQ-020 Counter width SHALL be max(1, ceil(log2(N))) bits; cnt SHALL never exceed N-1.
REQ-021 N==1: each window SHALL produce exactly one beat with out_last=1.
REQ-022 x_out SHALL be 0 whenever out_valid==0.

Reset
REQ-023 Assertion of rst at any time, including mid-window, SHALL force IDLE, cnt=0, holding register=0, out_valid=0, out_last=0, x_out=0, and in_ready=1 after the state change; the partial window SHALL be discarded.
REQ-024 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro CNN_SERIALIZER_REVERSE_EN defined: beat k SHALL emit element N-1-k (highest element first); out_last SHALL mark element 0.
REQ-026 Macro undefined: beat k SHALL emit element k (element 0 first); all other behaviour identical.

Structure
REQ-027 The state encoding localparams and the counter-width function SHALL reside in the shared package cnn_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the holding register, counter and FSM are local.

Verification
REQ-029 IN_WIDTH=12, N=5, x_in={005,004,003,002,001}h, out_ready=1 -> x_out 001,002,003,004,005 on the 5 cycles after accept, out_last only with 005.
REQ-030 Two windows, in_valid held 1, out_ready=1 -> 10 consecutive valid beats, no bubble, in_ready=1 only on cycles 0, 5, 10.
REQ-031 out_ready=0 for 3 cycles during beat 2 -> x_out holds 003, out_valid stays 1, resumes 004 after release.
REQ-032 rst pulsed during beat 3 -> out_valid=0, x_out=0 asynchronously; next window restarts at element 0.
REQ-033 CNN_SERIALIZER_REVERSE_EN defined, same stimulus as REQ-029 -> 005,004,003,002,001, out_last with 001.
REQ-034 N=1, x_in=12'hABC -> one beat ABC with out_last=1, then IDLE.
